// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package fifo_uart_pkg;

    // Transmitter FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_CAP   = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PAR   = 3'd5;
`endif
    localparam logic [2:0] ST_STOP  = 3'd6;

    // Frame lengths in serial bits: start + 8 data (+ parity) + stop
    localparam int unsigned FRAME_BITS_NO_PAR = 10;
    localparam int unsigned FRAME_BITS_PAR    = 11;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = FRAME_BITS_PAR;
`else
    localparam int unsigned FRAME_BITS = FRAME_BITS_NO_PAR;
`endif

    // Level of the serial line whenever no frame is on the wire
    localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

endpackage

// File: rtl/fifo_uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and pulses bit_end on the last one.
// Held at zero while clear is high so a frame always starts on a fresh bit period.
// Optional feature macro UART_TX_PARITY_EN does not affect this block.
module fifo_uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Baud counter: wraps to 0 at the end of each bit period
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // End-of-bit strobe, suppressed while the timer is held clear
    always_comb begin
        bit_end = !clear && (cnt == CNT_LAST);
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream synchronous FIFO.
// Sequence per byte: IDLE -> RD (pop) -> CAP (latch data) -> START -> DATA x8 -> STOP.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit (PAR) before STOP.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       empty,
    input  logic [7:0] fifo_data,
    output logic       read,
    output logic       tx,
    output logic       busy
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       bit_end;
    logic       baud_clear;
`ifdef UART_TX_PARITY_EN
    logic       parity;
`endif

    // Timer only runs while a frame is on the wire
    always_comb begin
        baud_clear = (state == ST_IDLE) || (state == ST_RD) || (state == ST_CAP);
    end

    fifo_uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!empty) state_next = ST_RD;
            ST_RD:    state_next = ST_CAP;
            ST_CAP:   state_next = ST_START;
            ST_START: if (bit_end) state_next = ST_DATA;
            ST_DATA: begin
                if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PAR;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PAR:   if (bit_end) state_next = ST_STOP;
`endif
            ST_STOP:  if (bit_end) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift register and bit counter: load in CAP, shift right at each data bit end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (state == ST_CAP) begin
            shreg   <= fifo_data;
            bit_cnt <= '0;
        end else if ((state == ST_DATA) && bit_end) begin
            shreg   <= {1'b0, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte as captured, before shifting destroys it
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            parity <= 1'b0;
        end else if (state == ST_CAP) begin
            parity <= even_parity(fifo_data);
        end
    end
`endif

    // Outputs decoded from state; reset forces IDLE so tx goes high asynchronously
    always_comb begin
        tx = IDLE_LEVEL;
        case (state)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PAR:   tx = parity;
`endif
            default:  tx = IDLE_LEVEL;
        endcase
        read = (state == ST_RD);
        busy = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with CLKS_PER_BIT=4 and a one-cycle registered-read FIFO model.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame as well.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;
    localparam int GAP = 3;

    logic       CLK;
    logic       RSTn;
    logic       empty;
    logic [7:0] fifo_data;
    logic       read;
    logic       tx;
    logic       busy;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .empty     (empty),
        .fifo_data (fifo_data),
        .read      (read),
        .tx        (tx),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int read_cnt = 0;
    int frames_done = 0;
    int exp_rd = 0;
    int wr_idx = 0;

    logic [7:0] stim_bytes[$];   // append-only, consumed by the FIFO model via wr_idx
    logic [8:0] exp_q[$];        // append-only {parity, data}, consumed by monitor via exp_rd
    logic [7:0] fifo_q[$];
    int         start_times[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // FIFO model: pop on read, data valid the cycle after
    initial begin : fifo_model
        logic [7:0] v;
        logic       popped;
        empty     = 1'b1;
        fifo_data = '0;
        forever begin
            @(posedge CLK);
            cyc++;
            popped = 1'b0;
            v      = '0;
            if (read === 1'b1 && fifo_q.size() > 0) begin
                v      = fifo_q.pop_front();
                popped = 1'b1;
            end
            while (wr_idx < stim_bytes.size()) begin
                fifo_q.push_back(stim_bytes[wr_idx]);
                wr_idx++;
            end
            if (popped) fifo_data <= v;
            empty <= (fifo_q.size() == 0);
        end
    end

    // Read strobe monitor
    initial begin : read_mon
        forever begin
            @(negedge CLK);
            if (read === 1'b1) begin
                read_cnt++;
                check("read_while_empty", empty, 0);
            end
        end
    end

    task automatic decode_frame();
        logic [NBITS-1:0] bits = '0;
        logic [8:0]       expv;
        bit               stable = 1'b1;
        int               t0 = cyc;
        for (int b = 0; b < NBITS; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (b != 0 || c != 0) @(negedge CLK);
                if (RSTn !== 1'b1) return;
                if (c == 0) bits[b] = tx;
                else if (tx !== bits[b]) stable = 1'b0;
            end
        end
        frames_done++;
        start_times.push_back(t0);
        check("bit_hold", stable, 1);
        check("start_bit", bits[0], 0);
        check("stop_bit", bits[NBITS-1], 1);
        check("frame_expected", exp_rd < exp_q.size(), 1);
        if (exp_rd < exp_q.size()) begin
            expv = exp_q[exp_rd];
            exp_rd++;
            check("data", bits[8:1], expv[7:0]);
`ifdef UART_TX_PARITY_EN
            check("parity", bits[9], expv[8]);
`endif
        end
    endtask

    // Serial line monitor: decode every frame and score it against the expected queue
    initial begin : line_mon
        forever begin
            @(negedge CLK);
            if (RSTn === 1'b1 && tx === 1'b0) decode_frame();
        end
    end

    task automatic push_byte(input logic [7:0] b, input logic par);
        stim_bytes.push_back(b);
        exp_q.push_back({par, b});
    endtask

    task automatic wait_frames(input int target, input int limit, input string name);
        int n = 0;
        while (frames_done < target && n < limit) begin
            @(negedge CLK);
            n++;
        end
        check(name, frames_done >= target, 1);
    endtask

    initial begin : stim
        int rd0;
        int s0;
        int fd;
        int n;
        RSTn = 1'b0;

        // Reset held with a byte waiting: outputs stay quiet
        push_byte(8'hA5, 1'b0);
        repeat (10) begin
            @(negedge CLK);
            check("rst_read", read, 0);
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
        end
        check("rst_fifo_nonempty", empty, 0);

        // Release: 0xA5 goes out as one frame with one pop
        rd0 = read_cnt;
        RSTn = 1'b1;
        wait_frames(1, 200, "frame_a5_done");
        @(negedge CLK);
        check("a5_busy_after", busy, 0);
        check("a5_tx_after", tx, 1);
        check("a5_reads", read_cnt - rd0, 1);

        // Three queued bytes back to back
        rd0 = read_cnt;
        s0  = start_times.size();
        fd  = frames_done;
        push_byte(8'h01, 1'b1);
        push_byte(8'h80, 1'b1);
        push_byte(8'hFF, 1'b0);
        wait_frames(fd + 3, 600, "frames_3_done");
        @(negedge CLK);
        check("burst_reads", read_cnt - rd0, 3);
        if (start_times.size() >= s0 + 3) begin
            check("gap_1", start_times[s0+1] - start_times[s0], FRAME_CYC + GAP);
            check("gap_2", start_times[s0+2] - start_times[s0+1], FRAME_CYC + GAP);
        end

        // Empty FIFO for 200 cycles: line stays idle
        rd0 = read_cnt;
        repeat (200) begin
            @(negedge CLK);
            check("idle_read", read, 0);
            check("idle_tx", tx, 1);
        end
        check("idle_reads", read_cnt - rd0, 0);

        // Reset during data bit 3 of 0x55; 0x3C waits in the FIFO
        rd0 = read_cnt;
        fd  = frames_done;
        stim_bytes.push_back(8'h55);
        push_byte(8'h3C, 1'b0);
        n = 0;
        while (read !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("rd_seen", read, 1);
        repeat (18) @(negedge CLK);
        check("bit3_low", tx, 0);
        #1 RSTn = 1'b0;
        #1;
        check("rst_tx_async", tx, 1);
        check("rst_busy_async", busy, 0);
        repeat (3) @(negedge CLK);
        check("rst_tx_hold", tx, 1);
        RSTn = 1'b1;
        wait_frames(fd + 1, 200, "frame_after_reset");
        @(negedge CLK);
        check("reset_reads", read_cnt - rd0, 2);

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x03 -> 0, 0x07 -> 1
        s0 = start_times.size();
        fd = frames_done;
        push_byte(8'h03, 1'b0);
        push_byte(8'h07, 1'b1);
        wait_frames(fd + 2, 300, "parity_frames_done");
        if (start_times.size() >= s0 + 2) begin
            check("parity_gap", start_times[s0+1] - start_times[s0], 44 + GAP);
        end
`endif

        repeat (5) @(negedge CLK);
        check("all_frames_seen", exp_rd, exp_q.size());
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
